// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock
//   24-hour BCD real-time clock with NUM_ALARMS independent alarm channels.
//   The clock advances one second per clk_1s edge. Each channel has its own
//   HH:MM alarm register and a small IDLE/RINGING/SNOOZED state machine with
//   a ring timeout counter and a snooze countdown.
//
// Ports
//   clk_1s, reset            : 1 Hz clock, asynchronous active-high reset
//   h_in1..m_in0             : BCD HH:MM load value (time or alarm)
//   ld_time                  : load current time (seconds cleared)
//   ld_alarm, al_sel         : load alarm register al_sel
//   al_en                    : per-channel enable
//   stop_al, snooze          : global stop / snooze controls
//   h_out1..s_out0           : registered BCD current time
//   alarm, alarm_any         : per-channel ringing flags and their OR
//   snoozing                 : per-channel snooze-pending flags
module multi_alarm_clock #(
  parameter  int NUM_ALARMS     = 4,
  parameter  int SNOOZE_MIN     = 5,
  parameter  int RING_TIMEOUT_S = 60,
  localparam int AW             = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk_1s,
  input  logic                  reset,
  input  logic [1:0]            h_in1,
  input  logic [3:0]            h_in0,
  input  logic [3:0]            m_in1,
  input  logic [3:0]            m_in0,
  input  logic                  ld_time,
  input  logic                  ld_alarm,
  input  logic [AW-1:0]         al_sel,
  input  logic [NUM_ALARMS-1:0] al_en,
  input  logic                  stop_al,
  input  logic                  snooze,
  output logic [1:0]            h_out1,
  output logic [3:0]            h_out0,
  output logic [3:0]            m_out1,
  output logic [3:0]            m_out0,
  output logic [3:0]            s_out1,
  output logic [3:0]            s_out0,
  output logic [NUM_ALARMS-1:0] alarm,
  output logic                  alarm_any,
  output logic [NUM_ALARMS-1:0] snoozing
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_t;

  localparam logic [7:0]  RC_LAST    = 8'(RING_TIMEOUT_S - 1);
  localparam logic [11:0] SC_LOAD    = 12'(SNOOZE_MIN * 60 - 1);
  localparam logic [AW:0] NUM_AL_EXT = NUM_ALARMS[AW:0];

  // A BCD HH:MM value is usable only if every digit is decimal, minutes
  // tens are 0..5 and the hour is 00..23.
  function automatic logic hm_valid(input logic [1:0] h1, input logic [3:0] h0,
                                    input logic [3:0] m1, input logic [3:0] m0);
    logic hour_ok;
    hour_ok = (h1 < 2'd2) || ((h1 == 2'd2) && (h0 <= 4'd3));
    return hour_ok && (h0 <= 4'd9) && (m1 <= 4'd5) && (m0 <= 4'd9);
  endfunction

  logic                  load_ok;
  logic                  time_ld_ok;
  logic                  alarm_ld_ok;

  logic [1:0]            al_h1 [NUM_ALARMS];
  logic [3:0]            al_h0 [NUM_ALARMS];
  logic [3:0]            al_m1 [NUM_ALARMS];
  logic [3:0]            al_m0 [NUM_ALARMS];

  state_t                st     [NUM_ALARMS];
  state_t                nxt_st [NUM_ALARMS];
  logic [7:0]            rc     [NUM_ALARMS];
  logic [7:0]            nxt_rc [NUM_ALARMS];
  logic [11:0]           sc     [NUM_ALARMS];
  logic [11:0]           nxt_sc [NUM_ALARMS];

  logic [NUM_ALARMS-1:0] match;
  logic [NUM_ALARMS-1:0] ld_hit;
  logic [NUM_ALARMS-1:0] nxt_ring;
  logic [NUM_ALARMS-1:0] nxt_snz;

  assign load_ok     = hm_valid(h_in1, h_in0, m_in1, m_in0);
  assign time_ld_ok  = ld_time && load_ok;
  assign alarm_ld_ok = ld_alarm && load_ok && ({1'b0, al_sel} < NUM_AL_EXT);

  // ---- time of day: load or one-second BCD increment ----
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      h_out1 <= 2'd0;
      h_out0 <= 4'd0;
      m_out1 <= 4'd0;
      m_out0 <= 4'd0;
      s_out1 <= 4'd0;
      s_out0 <= 4'd0;
    end else if (time_ld_ok) begin
      h_out1 <= h_in1;
      h_out0 <= h_in0;
      m_out1 <= m_in1;
      m_out0 <= m_in0;
      s_out1 <= 4'd0;
      s_out0 <= 4'd0;
    end else if (s_out0 != 4'd9) begin
      s_out0 <= s_out0 + 4'd1;
    end else begin
      s_out0 <= 4'd0;
      if (s_out1 != 4'd5) begin
        s_out1 <= s_out1 + 4'd1;
      end else begin
        s_out1 <= 4'd0;
        if (m_out0 != 4'd9) begin
          m_out0 <= m_out0 + 4'd1;
        end else begin
          m_out0 <= 4'd0;
          if (m_out1 != 4'd5) begin
            m_out1 <= m_out1 + 4'd1;
          end else begin
            m_out1 <= 4'd0;
            // Hour wraps 23 -> 00; otherwise units roll into tens at 9.
            if ((h_out1 == 2'd2) && (h_out0 == 4'd3)) begin
              h_out1 <= 2'd0;
              h_out0 <= 4'd0;
            end else if (h_out0 == 4'd9) begin
              h_out1 <= h_out1 + 2'd1;
              h_out0 <= 4'd0;
            end else begin
              h_out0 <= h_out0 + 4'd1;
            end
          end
        end
      end
    end
  end

  // ---- alarm registers ----
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        al_h1[i] <= 2'd0;
        al_h0[i] <= 4'd0;
        al_m1[i] <= 4'd0;
        al_m0[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (ld_hit[i]) begin
          al_h1[i] <= h_in1;
          al_h0[i] <= h_in0;
          al_m1[i] <= m_in1;
          al_m0[i] <= m_in0;
        end
      end
    end
  end

  // ---- per-channel match and next-state ----
  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      ld_hit[i] = alarm_ld_ok && (al_sel == AW'(i));
      match[i]  = al_en[i] &&
                  (h_out1 == al_h1[i]) && (h_out0 == al_h0[i]) &&
                  (m_out1 == al_m1[i]) && (m_out0 == al_m0[i]) &&
                  (s_out1 == 4'd0) && (s_out0 == 4'd0);

      nxt_st[i] = st[i];
      nxt_rc[i] = rc[i];
      nxt_sc[i] = sc[i];

      if (!al_en[i] || stop_al || ld_hit[i]) begin
        nxt_st[i] = IDLE;
      end else if (snooze && (st[i] == RINGING)) begin
        nxt_st[i] = SNOOZED;
        nxt_sc[i] = SC_LOAD;
      end else begin
        case (st[i])
          RINGING: begin
            if (rc[i] == RC_LAST) begin
              nxt_st[i] = IDLE;
            end else begin
              nxt_rc[i] = rc[i] + 8'd1;
            end
          end
          SNOOZED: begin
            if (sc[i] == 12'd0) begin
              nxt_st[i] = RINGING;
              nxt_rc[i] = 8'd0;
            end else begin
              nxt_sc[i] = sc[i] - 12'd1;
            end
          end
          default: begin
            // A match is only acted on from IDLE.
            if (match[i]) begin
              nxt_st[i] = RINGING;
              nxt_rc[i] = 8'd0;
            end
          end
        endcase
      end

      nxt_ring[i] = (nxt_st[i] == RINGING);
      nxt_snz[i]  = (nxt_st[i] == SNOOZED);
    end
  end

  // ---- channel state and registered flags ----
  // alarm_any is taken from next-state bits so it lines up with alarm.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        st[i] <= IDLE;
        rc[i] <= 8'd0;
        sc[i] <= 12'd0;
      end
      alarm     <= '0;
      snoozing  <= '0;
      alarm_any <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        st[i] <= nxt_st[i];
        rc[i] <= nxt_rc[i];
        sc[i] <= nxt_sc[i];
      end
      alarm     <= nxt_ring;
      snoozing  <= nxt_snz;
      alarm_any <= |nxt_ring;
    end
  end

endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb_multi_alarm_clock
//   Directed bench for multi_alarm_clock with default parameters
//   (4 channels, 5 minute snooze, 60 s ring timeout).
module tb_multi_alarm_clock;

  logic       clk_1s = 1'b0;
  logic       reset;
  logic [1:0] h_in1;
  logic [3:0] h_in0, m_in1, m_in0;
  logic       ld_time, ld_alarm;
  logic [1:0] al_sel;
  logic [3:0] al_en;
  logic       stop_al, snooze;
  logic [1:0] h_out1;
  logic [3:0] h_out0, m_out1, m_out0, s_out1, s_out0;
  logic [3:0] alarm;
  logic       alarm_any;
  logic [3:0] snoozing;

  int n_cmp = 0;
  int n_bad = 0;

  multi_alarm_clock dut (
    .clk_1s    (clk_1s),
    .reset     (reset),
    .h_in1     (h_in1),
    .h_in0     (h_in0),
    .m_in1     (m_in1),
    .m_in0     (m_in0),
    .ld_time   (ld_time),
    .ld_alarm  (ld_alarm),
    .al_sel    (al_sel),
    .al_en     (al_en),
    .stop_al   (stop_al),
    .snooze    (snooze),
    .h_out1    (h_out1),
    .h_out0    (h_out0),
    .m_out1    (m_out1),
    .m_out0    (m_out0),
    .s_out1    (s_out1),
    .s_out0    (s_out0),
    .alarm     (alarm),
    .alarm_any (alarm_any),
    .snoozing  (snoozing)
  );

  always #5 clk_1s = ~clk_1s;

  typedef struct {
    logic [1:0]  h1;
    logic [3:0]  h0;
    logic [3:0]  m1;
    logic [3:0]  m0;
    logic        ld;
    int          n;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [21:0] disp();
    return {h_out1, h_out0, m_out1, m_out0, s_out1, s_out0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_1s);
    #1;
  endtask

  task automatic set_hm(input logic [1:0] h1, input logic [3:0] h0,
                        input logic [3:0] m1, input logic [3:0] m0);
    h_in1 = h1; h_in0 = h0; m_in1 = m1; m_in0 = m0;
  endtask

  initial begin
    int cnt;

    // Each row: drive HH:MM with ld_time=ld on the first edge, n edges total.
    tbl[0]  = '{2'd2, 4'd3, 4'd5, 4'd9,  1'b1, 60, 22'h235959};
    tbl[1]  = '{2'd0, 4'd0, 4'd0, 4'd0,  1'b0, 1,  22'h000000};
    tbl[2]  = '{2'd0, 4'd0, 4'd0, 4'd0,  1'b0, 1,  22'h000001};
    tbl[3]  = '{2'd0, 4'd9, 4'd5, 4'd9,  1'b1, 60, 22'h095959};
    tbl[4]  = '{2'd0, 4'd0, 4'd0, 4'd0,  1'b0, 1,  22'h100000};
    tbl[5]  = '{2'd1, 4'd9, 4'd5, 4'd9,  1'b1, 61, 22'h200000};
    tbl[6]  = '{2'd2, 4'd5, 4'd0, 4'd0,  1'b1, 1,  22'h200001};
    tbl[7]  = '{2'd1, 4'd2, 4'd6, 4'd0,  1'b1, 1,  22'h200002};
    tbl[8]  = '{2'd1, 4'd2, 4'd3, 4'hA,  1'b1, 1,  22'h200003};
    tbl[9]  = '{2'd3, 4'd0, 4'd0, 4'd0,  1'b1, 1,  22'h200004};
    tbl[10] = '{2'd0, 4'd0, 4'd0, 4'd0,  1'b1, 1,  22'h000000};
    tbl[11] = '{2'd2, 4'd3, 4'd4, 4'd5,  1'b1, 10, 22'h234509};
    tbl[12] = '{2'd1, 4'hA, 4'd0, 4'd0,  1'b1, 1,  22'h234510};
    tbl[13] = '{2'd2, 4'd4, 4'd0, 4'd0,  1'b1, 1,  22'h234511};
    tbl[14] = '{2'd1, 4'd5, 4'd5, 4'd9,  1'b1, 1,  22'h155900};

    reset = 1'b1;
    set_hm(2'd0, 4'd0, 4'd0, 4'd0);
    ld_time = 1'b0; ld_alarm = 1'b0; al_sel = 2'd0; al_en = 4'b0000;
    stop_al = 1'b0; snooze = 1'b0;

    // Reset state
    tick();
    tick();
    check("reset_time", 32'(disp()), 32'h000000);
    check("reset_alarm", 32'(alarm), 32'h0);
    check("reset_any", 32'(alarm_any), 32'h0);
    check("reset_snz", 32'(snoozing), 32'h0);
    reset = 1'b0;

    // Time-keeping vectors
    for (int r = 0; r < 15; r++) begin
      set_hm(tbl[r].h1, tbl[r].h0, tbl[r].m1, tbl[r].m0);
      ld_time = tbl[r].ld;
      tick();
      ld_time = 1'b0;
      for (int k = 1; k < tbl[r].n; k++) tick();
      check($sformatf("vec%0d_time", r), 32'(disp()), 32'(tbl[r].exp));
      check($sformatf("vec%0d_alarm", r), 32'(alarm), 32'h0);
    end

    // Single alarm on channel 2 at 07:30
    set_hm(2'd0, 4'd7, 4'd3, 4'd0);
    ld_alarm = 1'b1; al_sel = 2'd2;
    tick();
    ld_alarm = 1'b0;
    set_hm(2'd0, 4'd7, 4'd2, 4'd9);
    ld_time = 1'b1; al_en = 4'b0100;
    tick();
    ld_time = 1'b0;
    repeat (60) tick();
    check("single_pre_time", 32'(disp()), 32'h073000);
    check("single_pre_alarm", 32'(alarm), 32'h0);
    tick();
    check("single_rise_time", 32'(disp()), 32'h073001);
    check("single_rise_alarm", 32'(alarm), 32'h4);
    check("single_rise_any", 32'(alarm_any), 32'h1);
    check("single_rise_snz", 32'(snoozing), 32'h0);
    cnt = 1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (alarm !== 4'b0100) break;
      cnt++;
    end
    check("single_ring_len", 32'(cnt), 32'd60);
    check("single_fall_alarm", 32'(alarm), 32'h0);
    check("single_fall_any", 32'(alarm_any), 32'h0);

    // Snooze on channel 0 at 07:30:10
    al_en = 4'b0000;
    set_hm(2'd0, 4'd7, 4'd3, 4'd0);
    ld_alarm = 1'b1; al_sel = 2'd0;
    tick();
    ld_alarm = 1'b0;
    set_hm(2'd0, 4'd7, 4'd2, 4'd9);
    ld_time = 1'b1; al_en = 4'b0001;
    tick();
    ld_time = 1'b0;
    repeat (61) tick();
    check("snz_ring_alarm", 32'(alarm), 32'h1);
    repeat (9) tick();
    check("snz_at_time", 32'(disp()), 32'h073010);
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    check("snz_start_alarm", 32'(alarm), 32'h0);
    check("snz_start_snz", 32'(snoozing), 32'h1);
    check("snz_start_any", 32'(alarm_any), 32'h0);
    check("snz_start_time", 32'(disp()), 32'h073011);
    cnt = 1;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (snoozing !== 4'b0001) break;
      cnt++;
    end
    check("snz_len", 32'(cnt), 32'd300);
    check("snz_rering_alarm", 32'(alarm), 32'h1);
    check("snz_rering_any", 32'(alarm_any), 32'h1);
    check("snz_rering_time", 32'(disp()), 32'h073511);

    // Stop and snooze together: stop wins
    repeat (2) tick();
    stop_al = 1'b1; snooze = 1'b1;
    tick();
    stop_al = 1'b0; snooze = 1'b0;
    check("stop_alarm", 32'(alarm), 32'h0);
    check("stop_snz", 32'(snoozing), 32'h0);
    check("stop_any", 32'(alarm_any), 32'h0);
    repeat (5) tick();
    check("stop_hold", 32'({alarm, snoozing}), 32'h0);

    // Simultaneous alarms on channels 1 and 3 at 12:00
    al_en = 4'b0000;
    set_hm(2'd1, 4'd2, 4'd0, 4'd0);
    ld_alarm = 1'b1; al_sel = 2'd1;
    tick();
    al_sel = 2'd3;
    ld_time = 1'b1;
    set_hm(2'd1, 4'd2, 4'd0, 4'd0);
    // Time loads 11:59 on the same edge as alarm 3 loads 12:00 is impossible
    // with shared inputs, so load alarm 3 first then the time.
    tick();
    ld_alarm = 1'b0;
    set_hm(2'd1, 4'd1, 4'd5, 4'd9);
    tick();
    ld_time = 1'b0;
    al_en = 4'b1111;
    repeat (60) tick();
    check("simul_pre_time", 32'(disp()), 32'h120000);
    check("simul_pre_alarm", 32'(alarm), 32'h0);
    tick();
    check("simul_rise_alarm", 32'(alarm), 32'hA);
    check("simul_rise_any", 32'(alarm_any), 32'h1);
    check("simul_rise_time", 32'(disp()), 32'h120001);
    repeat (3) tick();
    al_en = 4'b1101;
    tick();
    check("simul_drop1_alarm", 32'(alarm), 32'h8);
    check("simul_drop1_any", 32'(alarm_any), 32'h1);
    al_en = 4'b0000;
    tick();
    check("simul_off_alarm", 32'(alarm), 32'h0);
    check("simul_off_any", 32'(alarm_any), 32'h0);

    // Invalid alarm load (minutes tens = 6) leaves channel 0 at 07:30
    set_hm(2'd1, 4'd2, 4'd6, 4'd0);
    ld_alarm = 1'b1; al_sel = 2'd0;
    tick();
    ld_alarm = 1'b0;
    set_hm(2'd0, 4'd7, 4'd2, 4'd9);
    ld_time = 1'b1; al_en = 4'b0001;
    tick();
    ld_time = 1'b0;
    repeat (61) tick();
    check("badld_time", 32'(disp()), 32'h073001);
    check("badld_alarm", 32'(alarm), 32'h1);

    // Asynchronous reset while ringing; no time load during reset
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    check("areset_time", 32'(disp()), 32'h000000);
    check("areset_alarm", 32'(alarm), 32'h0);
    check("areset_any", 32'(alarm_any), 32'h0);
    check("areset_snz", 32'(snoozing), 32'h0);
    set_hm(2'd1, 4'd2, 4'd3, 4'd4);
    ld_time = 1'b1;
    tick();
    check("reset_noload", 32'(disp()), 32'h000000);
    ld_time = 1'b0;
    reset = 1'b0;
    // Channel 0 register is back to 00:00 and time shows 00:00:00.
    tick();
    check("post_reset_time", 32'(disp()), 32'h000001);
    check("post_reset_alarm", 32'(alarm), 32'h1);

    // Alarm at 00:00 fires after the midnight wrap
    stop_al = 1'b1;
    tick();
    stop_al = 1'b0;
    set_hm(2'd2, 4'd3, 4'd5, 4'd9);
    ld_time = 1'b1;
    tick();
    ld_time = 1'b0;
    repeat (59) tick();
    check("wrap_pre_time", 32'(disp()), 32'h235959);
    check("wrap_pre_alarm", 32'(alarm), 32'h0);
    tick();
    check("wrap_zero_time", 32'(disp()), 32'h000000);
    check("wrap_zero_alarm", 32'(alarm), 32'h0);
    tick();
    check("wrap_fire_alarm", 32'(alarm), 32'h1);
    check("wrap_fire_time", 32'(disp()), 32'h000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

Parametrised 24-hour real-time clock with NUM_ALARMS independent alarm channels, each with enable, snooze, and auto-timeout. It advances once per clk_1s edge and holds time as BCD digits for direct display drive. It is the next-generation replacement for the single-alarm clock block and sits downstream of the 10 Hz-to-1 Hz divider.

## Interface
Parameters:
- NUM_ALARMS, 4: number of alarm channels, 1..8
- SNOOZE_MIN, 5: snooze length in minutes, 1..59
- RING_TIMEOUT_S, 60: cycles an alarm rings before auto-stop, 1..255
- AW = (NUM_ALARMS>1) ? $clog2(NUM_ALARMS) : 1 (localparam)

Ports:
- clk_1s, in, 1: 1 Hz clock; one tick = one second
- reset, in, 1: asynchronous, active-high; clock clk_1s
- h_in1, in, 2 / h_in0, in, 4 / m_in1, in, 4 / m_in0, in, 4: BCD load value HH:MM
- ld_time, in, 1: load current time from inputs; seconds := 00
- ld_alarm, in, 1: load alarm register al_sel from inputs
- al_sel, in, AW: alarm channel index for ld_alarm
- al_en, in, NUM_ALARMS: per-channel alarm enable
- stop_al, in, 1: stop all ringing or snoozed channels
- snooze, in, 1: move all ringing channels to snooze
- h_out1 (2), h_out0, m_out1, m_out0, s_out1, s_out0 (4 each), out: BCD current time
- alarm, out, NUM_ALARMS: per-channel ringing flag
- alarm_any, out, 1: OR of alarm
- snoozing, out, NUM_ALARMS: per-channel snooze-pending flag

## Operation
- Time is kept in six BCD digit registers and increments by 1 s per edge. Carries are s0 9->0, s1 5->0, m0 9->0, m1 5->0, h 09->10, 19->20, 23:59:59->00:00:00.
- ld_time=1: time := inputs, seconds := 00, and there is no increment that cycle. If the load value is invalid (hour > 23, m_in1 > 5, any digit > 9), the clock ignores the load and ticks normally.
- ld_alarm=1: alarm register[al_sel] := HH:MM, and channel al_sel is forced to IDLE. An invalid value is ignored, or an al_sel >= NUM_ALARMS. ld_time and ld_alarm are independent and may be applied together.
- Match for channel i: the registered time equals alarm[i] HH:MM:00 and al_en[i]=1.
- Per-channel FSM, with 8-bit ring counter rc and 12-bit snooze counter sc:
  - IDLE -> RINGING on match; rc := 0.
  - RINGING: rc increments each cycle. The channel goes to IDLE when rc = RING_TIMEOUT_S-1. It goes to SNOOZED on snooze, with sc := SNOOZE_MIN*60-1.
  - SNOOZED: sc decrements each cycle. The channel goes to RINGING when sc = 0, with rc := 0.
- Priority per channel, highest first: reset > al_en[i]=0 (forces IDLE) > stop_al (-> IDLE) > ld_alarm on this channel > snooze > timeout/expiry > match.
- A match while RINGING or SNOOZED is ignored.
- alarm[i] = (state==RINGING); snoozing[i] = (state==SNOOZED).
- alarm_any is a registered OR of the next-state alarm bits, so it is cycle-aligned with alarm.

## Timing
- All outputs are registered.
- Reset values: time 00:00:00, all alarm registers 00:00, all FSMs IDLE, alarm=0, alarm_any=0, snoozing=0.
- Asserting reset mid-ring clears everything immediately (asynchronously). Time does not load from the inputs on reset.
- Match latency is 1 cycle. The match is evaluated while time shows HH:MM:00, and alarm[i] rises on the edge where time becomes HH:MM:01.
- Ring duration: alarm[i] is high for exactly RING_TIMEOUT_S edges.
- Control latency: snooze or stop_al sampled at edge k takes effect on the outputs after edge k.
- Snooze duration: snoozing[i] is high for exactly SNOOZE_MIN*60 cycles, then alarm[i] is high again.
- A time load that lands exactly on HH:MM:00 of an enabled alarm fires that alarm one cycle later.
- Alarm HH:MM at 00:00 fires after the 23:59:59 wrap.

## Test plan
- Rollover: load 23:59 and run 60 ticks -> display reads 23:59:59, then 00:00:00. The next tick reads 00:00:01.
- Single alarm: alarm[2]=07:30, al_en=4'b0100, time 07:29 -> alarm[2] rises when the display shows 07:30:01, holds 60 cycles, then falls. Other bits stay 0.
- Snooze: ringing alarm[0] with snooze pulse at 07:30:10 -> alarm[0]=0 and snoozing[0]=1 for 300 cycles. alarm[0]=1 again at 07:35:11.
- Stop vs snooze: assert stop_al and snooze in the same cycle -> all channels IDLE, snoozing=0.
- Simultaneous alarms: alarm[1] and alarm[3] both 12:00, al_en all 1 -> both rise on the same edge, and alarm_any=1. Then clear al_en[1] mid-ring -> only alarm[1] drops on the next edge.
- Invalid loads: ld_time with 25:00 is ignored and time keeps ticking. ld_alarm with m_in1=6 leaves the register unchanged. Asserting reset during RINGING clears all outputs to reset values.
